// File: rtl/chacha_pkg.sv
// Shared state encoding and ChaCha20 core address map for the stream front end.
package chacha_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, STREAM} state_e;

  localparam int CONST_BASE  = 0;
  localparam int KEY_BASE    = 16;
  localparam int CTR_BASE    = 48;
  localparam int NONCE_BASE  = 52;
  localparam int BLOCK_BYTES = 64;

  // Little-endian byte select of the 32-bit block counter.
  function automatic logic [7:0] ctr_byte(input logic [31:0] ctr, input logic [1:0] sel);
    return ctr[8*sel +: 8];
  endfunction

endpackage

// File: rtl/chacha_stream_skid.sv
// One-entry ciphertext output register with valid/ready handshake.
module chacha_stream_skid (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       last_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       last_o,
  output logic       space_o
);

  logic       valid_q;
  logic [7:0] data_q;
  logic       last_q;

  // Space exists when empty or when the held byte leaves this cycle.
  assign space_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/chacha_stream.sv
// ChaCha20 stream front end: loads the block counter into the core, waits for the
// keystream and XORs it onto a byte stream. CHACHA_STREAM_CTR_GUARD_EN stops on counter wrap.
module chacha_stream
  import chacha_pkg::*;
#(
  parameter int CTR_BASE    = 48,
  parameter int BLOCK_BYTES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [5:0]  cfg_addr,
  input  logic [7:0]  cfg_data,
  input  logic        start,
  input  logic [31:0] ctr_init,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        busy,
  output logic        err,
  output logic        blk_write,
  output logic [5:0]  blk_addr,
  output logic [7:0]  blk_data,
  input  logic [7:0]  blk_rdata,
  input  logic        blk_ready
);

  localparam logic [5:0] LAST_IDX = 6'(BLOCK_BYTES - 1);

  state_e      state_q;
  logic [31:0] ctr_q;
  logic [1:0]  wcnt_q;
  logic [5:0]  idx_q;
  logic        space;
  logic        accept;

  assign in_ready = (state_q == STREAM) && space;
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != IDLE);

  // Host writes reach the core only while idle; LOAD owns the port otherwise.
  always_comb begin
    blk_write = 1'b0;
    blk_addr  = '0;
    blk_data  = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          blk_write = cfg_we;
          blk_addr  = cfg_addr;
          blk_data  = cfg_data;
        end
        LOAD: begin
          blk_write = 1'b1;
          blk_addr  = 6'(CTR_BASE) + {4'b0, wcnt_q};
          blk_data  = ctr_byte(ctr_q, wcnt_q);
        end
        STREAM:  blk_addr = idx_q;
        default: ;
      endcase
    end
  end

`ifdef CHACHA_STREAM_CTR_GUARD_EN
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      wcnt_q  <= '0;
      idx_q   <= '0;
`ifdef CHACHA_STREAM_CTR_GUARD_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            ctr_q   <= ctr_init;
            wcnt_q  <= '0;
            state_q <= LOAD;
`ifdef CHACHA_STREAM_CTR_GUARD_EN
            err_q   <= 1'b0;
`endif
          end
        end
        LOAD: begin
          wcnt_q <= wcnt_q + 2'd1;
          if (wcnt_q == 2'd3) state_q <= WAIT;
        end
        WAIT: begin
          if (blk_ready) begin
            idx_q   <= '0;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            idx_q <= idx_q + 6'd1;
            if (in_last) begin
              state_q <= IDLE;
            end else if (idx_q == LAST_IDX) begin
              // Block exhausted mid-message: fetch the next counter's keystream.
              ctr_q  <= ctr_q + 32'd1;
              wcnt_q <= '0;
`ifdef CHACHA_STREAM_CTR_GUARD_EN
              if (ctr_q == 32'hFFFF_FFFF) begin
                err_q   <= 1'b1;
                state_q <= IDLE;
              end else begin
                state_q <= LOAD;
              end
`else
              state_q <= LOAD;
`endif
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  chacha_stream_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept),
    .data_i  (in_data ^ blk_rdata),
    .last_i  (in_last),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  (out_data),
    .last_o  (out_last),
    .space_o (space)
  );

endmodule

// File: tb/tb_chacha_stream.sv
// Directed bench for chacha_stream with a behavioural ChaCha20 core model on the blk_* port.
module tb_chacha_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        start;
  logic [31:0] ctr_init;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;
  logic        err;
  logic        blk_write;
  logic [5:0]  blk_addr;
  logic [7:0]  blk_data;
  logic [7:0]  blk_rdata;
  logic        blk_ready;

  int nerr = 0;
  int nchk = 0;

  string PT = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";
  logic [7:0] RFC8 [8] = '{8'h6e, 8'h2e, 8'h35, 8'h9a, 8'h25, 8'h68, 8'hf9, 8'h80};

  always #5 clk = ~clk;

  chacha_stream dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .ctr_init(ctr_init), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .err(err),
    .blk_write(blk_write), .blk_addr(blk_addr), .blk_data(blk_data),
    .blk_rdata(blk_rdata), .blk_ready(blk_ready)
  );

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a_in, b_in, c_in, d_in);
    logic [31:0] a = a_in, b = b_in, c = c_in, d = d_in;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] chacha_block(input logic [511:0] st);
    logic [31:0]  x [16];
    logic [511:0] o;
    for (int i = 0; i < 16; i++) x[i] = st[32*i +: 32];
    for (int r = 0; r < 10; r++) begin
      {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
    end
    for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + st[32*i +: 32];
    return o;
  endfunction

  // Input block as the bench intends it: RFC key 00..1f, nonce byte 7 = 4a.
  function automatic logic [511:0] ref_state(input logic [31:0] c);
    string cs = "expand 32-byte k";
    logic [511:0] s = '0;
    for (int k = 0; k < 16; k++) s[8*k +: 8] = cs[k];
    for (int k = 0; k < 32; k++) s[8*(16 + k) +: 8] = 8'(k);
    s[8*48 +: 32] = c;
    s[8*59 +: 8]  = 8'h4a;
    return s;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [31:0] c, input int i);
    logic [511:0] ks = chacha_block(ref_state(c + 32'(i / 64)));
    return PT[i] ^ ks[8*(i % 64) +: 8];
  endfunction

  // Core model: byte-addressed state, any write restarts a 160-cycle computation.
  logic [511:0] cmem_flat = '0;
  logic [511:0] ks_blk = '0;
  logic         cready = 1'b0;
  int           ccnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      cready <= 1'b0;
      ccnt   <= 0;
    end else if (blk_write) begin
      cmem_flat[8*blk_addr +: 8] <= blk_data;
      cready <= 1'b0;
      ccnt   <= 160;
    end else if (ccnt > 1) begin
      ccnt <= ccnt - 1;
    end else if (ccnt == 1) begin
      ccnt   <= 0;
      ks_blk <= chacha_block(cmem_flat);
      cready <= 1'b1;
    end
  end

  assign blk_rdata = ks_blk[8*blk_addr +: 8];
  assign blk_ready = cready;

  logic [13:0] wlog [$];
  always @(posedge clk) if (!rst && blk_write) wlog.push_back({blk_addr, blk_data});

  logic [7:0] obuf [200];
  bit         olast [200];
  int         got;
  int         nbad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    if (obs !== expv) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic cfg_write(input logic [5:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    #1;
    check("cfg_pass", {blk_write, blk_addr, blk_data}, {1'b1, a, d});
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic run_msg(input logic [31:0] c, input int nbytes, input int want,
                         input bit bp, input bit noise);
    int sent = 0;
    int cyc = 0;
    bit pstall = 0;
    bit acc;
    logic [7:0] pdata = '0;
    got = 0; nbad = 0;
    wlog.delete();
    ctr_init = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (noise) begin cfg_we = 1'b1; cfg_addr = 6'd63; cfg_data = 8'h55; end
    in_valid = 1'b1; in_data = PT[0]; in_last = (nbytes == 1);
    while (got < want && cyc < 3000) begin
      out_ready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
      @(negedge clk);
      if (pstall && (!out_valid || out_data != pdata)) nbad++;
      pstall = out_valid && !out_ready;
      pdata  = out_data;
      if (out_valid && out_ready) begin
        obuf[got] = out_data; olast[got] = out_last; got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        if (in_last) begin
          in_valid = 1'b0; in_last = 1'b0; cfg_we = 1'b0;
        end else begin
          sent++; in_data = PT[sent]; in_last = (sent == nbytes - 1);
        end
      end
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    check("out_count", got, want);
  endtask

  task automatic check_wlog(input string tag, input logic [31:0] c, input int nloads);
    check({tag, "_wcount"}, wlog.size(), 4 * nloads);
    for (int k = 0; k < wlog.size() && k < 4 * nloads; k++) begin
      logic [31:0] cv = c + 32'(k / 4);
      check($sformatf("%s_w%0d", tag, k), wlog[k],
            {6'(chacha_pkg::CTR_BASE + k % 4), cv[8*(k % 4) +: 8]});
    end
  endtask

  task automatic check_bytes(input string tag, input logic [31:0] c, input int n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_b%0d", tag, i), obuf[i], exp_byte(c, i));
  endtask

  task automatic idle_outputs(input string tag, input int ncyc);
    int extra = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    @(posedge clk); #1;
    check({tag, "_extra_out"}, extra, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nl;
    rst = 1'b1; cfg_we = 1'b1; cfg_addr = 6'd5; cfg_data = 8'h77;
    start = 1'b0; ctr_init = '0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_blk", {blk_write, blk_addr, blk_data}, 15'd0);
    check("rst_out", {out_valid, out_data, out_last}, 10'd0);
    check("rst_ctl", {busy, in_ready, err}, 3'd0);
    @(posedge clk); #1;
    rst = 1'b0; cfg_we = 1'b0;

    for (int k = 0; k < 16; k++) cfg_write(6'(chacha_pkg::CONST_BASE + k), ref_state(0)[8*k +: 8]);
    for (int k = 0; k < 32; k++) cfg_write(6'(chacha_pkg::KEY_BASE + k), 8'(k));
    for (int k = 0; k < 12; k++) cfg_write(6'(chacha_pkg::NONCE_BASE + k), (k == 7) ? 8'h4a : 8'h00);

    // RFC 8439 message, no backpressure.
    run_msg(32'd1, 114, 114, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) check($sformatf("rfc_b%0d", i), obuf[i], RFC8[i]);
    check_bytes("s1", 32'd1, 114);
    nl = 0;
    for (int i = 0; i < 114; i++) nl += olast[i];
    check("s1_last_pos", olast[113], 1);
    check("s1_last_count", nl, 1);
    check_wlog("s1", 32'd1, 2);
    idle_outputs("s1", 20);
    check("s1_idle", {busy, err}, 2'd0);

    // Same message under ~30% out_ready with cfg writes attempted throughout.
    run_msg(32'd1, 114, 114, 1'b1, 1'b1);
    check_bytes("s2", 32'd1, 114);
    check("s2_stall_stable", nbad, 0);
    check("s2_last_pos", olast[113], 1);
    check_wlog("s2", 32'd1, 2);
    idle_outputs("s2", 20);

    // Reset at byte 30, then restart from byte 0.
    run_msg(32'd1, 114, 30, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_state", {out_valid, busy, in_ready}, 3'd0);
    idle_outputs("mid_rst", 200);
    run_msg(32'd1, 1, 1, 1'b0, 1'b0);
    check("restart_b0", obuf[0], 8'h6e);
    check("restart_last", olast[0], 1);

    // Counter wrap from 0xFFFFFFFF with a 65-byte message.
`ifdef CHACHA_STREAM_CTR_GUARD_EN
    run_msg(32'hFFFF_FFFF, 65, 64, 1'b0, 1'b0);
    check_bytes("wrap", 32'hFFFF_FFFF, 64);
    check("wrap_err", err, 1);
    check("wrap_idle", {busy, in_ready}, 2'd0);
    idle_outputs("wrap", 300);
    check_wlog("wrap", 32'hFFFF_FFFF, 1);
    check("wrap_err_sticky", err, 1);
`else
    run_msg(32'hFFFF_FFFF, 65, 65, 1'b0, 1'b0);
    check_bytes("wrap", 32'hFFFF_FFFF, 65);
    check("wrap_err", err, 0);
    check("wrap_last", olast[64], 1);
    check_wlog("wrap", 32'hFFFF_FFFF, 2);
    idle_outputs("wrap", 20);
`endif

    // Fresh start after the wrap run: err clears, stream resumes.
    run_msg(32'd5, 1, 1, 1'b0, 1'b0);
    check("post_err", err, 0);
    check("post_b0", obuf[0], exp_byte(32'd5, 0));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
